tpm_response_marshaller: RTL and testbench

//  Transmit-side counterpart of the I/O command path: converts execution-engine results into a TPM 2.0 response byte stream.
//  - Inputs: response tag, response code and a parameter area.
//  - Output: a big-endian byte stream on a valid/ready interface into the I/O block's response FIFO.
//  - Builds the 10-byte header (tag, responseSize, responseCode), then streams parameter bytes from a sync-read buffer.

---
 rtl/tpm_response_marshaller.sv | 210 +++++++++++++++++++++
 tb/tb_tpm_response_marshaller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tpm_response_marshaller.sv
// TPM 2.0 response marshaller: serialises tag/size/code header and the parameter area
// from a sync-read buffer onto a big-endian valid/ready byte stream.
module tpm_response_marshaller #(
    parameter int unsigned MAX_PARAM_BYTES = 64,
    parameter int unsigned PARAM_AW        = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                rsp_start,
    input  logic [15:0]         rsp_tag,
    input  logic [31:0]         rsp_code,
    input  logic [15:0]         param_len,
    output logic                param_rd_en,
    output logic [PARAM_AW-1:0] param_rd_addr,
    input  logic [7:0]          param_rd_data,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic                byte_last,
    output logic                busy,
    output logic                done,
    output logic [31:0]         rsp_size
);

    localparam int unsigned PlenW = $clog2(MAX_PARAM_BYTES + 1);
    localparam logic [15:0] TagNoSessions = 16'h8001;
    localparam logic [31:0] RcFailure     = 32'h0000_0101;

    typedef enum logic [1:0] {Idle, Hdr, Param, Done} state_t;

    state_t              state;
    logic [15:0]         tagQ;
    logic [31:0]         codeQ;
    logic [PlenW-1:0]    plenQ;
    logic [3:0]          hdrIdx;
    logic [PARAM_AW-1:0] rdAddr;
    logic                rdDone;
    logic                rdPend;
    logic                skidValid;
    logic [7:0]          skidData;
    logic [PlenW-1:0]    outCnt;

    logic [15:0]      newTag;
    logic [31:0]      newCode;
    logic [PlenW-1:0] newPlen;
    logic             hdrEnd;
    logic             paramEnd;
    logic             adv;
    logic             wantParam;
    logic             loadParam;
    logic [7:0]       nextParamByte;
    logic             skidNextValid;
    logic [7:0]       skidNextData;

    function automatic logic [7:0] hdrByte(input logic [3:0] idx, input logic [15:0] tag,
                                           input logic [31:0] size, input logic [31:0] code);
        logic [7:0] b;
        case (idx)
            4'd0:    b = tag[15:8];
            4'd1:    b = tag[7:0];
            4'd2:    b = size[31:24];
            4'd3:    b = size[23:16];
            4'd4:    b = size[15:8];
            4'd5:    b = size[7:0];
            4'd6:    b = code[31:24];
            4'd7:    b = code[23:16];
            4'd8:    b = code[15:8];
            4'd9:    b = code[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Error and oversize responses carry no parameters and the no-sessions tag.
    always_comb begin
        newTag  = rsp_tag;
        newCode = 32'h0;
        newPlen = param_len[PlenW-1:0];
        if (rsp_code != 32'h0) begin
            newTag  = TagNoSessions;
            newCode = rsp_code;
            newPlen = '0;
        end else if (32'(param_len) > MAX_PARAM_BYTES) begin
            newTag  = TagNoSessions;
            newCode = RcFailure;
            newPlen = '0;
        end
    end

    always_comb begin
        adv           = !byte_valid || byte_ready;
        hdrEnd        = (state == Hdr) && byte_ready && (hdrIdx == 4'd9);
        paramEnd      = (state == Param) && byte_valid && byte_ready && byte_last;
        wantParam     = (hdrEnd && (plenQ != '0)) || ((state == Param) && adv && !paramEnd);
        loadParam     = wantParam && (skidValid || rdPend);
        nextParamByte = skidValid ? skidData : param_rd_data;
        // Returning read data bypasses the skid only when it goes straight to the output.
        if (loadParam) begin
            skidNextValid = skidValid && rdPend;
        end else begin
            skidNextValid = skidValid || rdPend;
        end
        skidNextData = (rdPend && !(loadParam && !skidValid)) ? param_rd_data : skidData;
        // A read is only issued when its data is guaranteed a free skid slot next cycle.
        param_rd_en  = ((state == Hdr) || (state == Param)) && !rdDone && !skidNextValid;
    end

    assign param_rd_addr = rdAddr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= Idle;
            tagQ       <= '0;
            codeQ      <= '0;
            plenQ      <= '0;
            hdrIdx     <= '0;
            rdAddr     <= '0;
            rdDone     <= 1'b0;
            rdPend     <= 1'b0;
            skidValid  <= 1'b0;
            skidData   <= '0;
            outCnt     <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rsp_size   <= '0;
        end else begin
            unique case (state)
                Idle: begin
                    if (rsp_start) begin
                        tagQ       <= newTag;
                        codeQ      <= newCode;
                        plenQ      <= newPlen;
                        rsp_size   <= 32'd10 + 32'(newPlen);
                        hdrIdx     <= '0;
                        rdAddr     <= '0;
                        rdDone     <= (newPlen == '0);
                        rdPend     <= 1'b0;
                        skidValid  <= 1'b0;
                        outCnt     <= '0;
                        byte_out   <= newTag[15:8];
                        byte_valid <= 1'b1;
                        byte_last  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= Hdr;
                    end
                end
                Hdr: begin
                    if (byte_ready) begin
                        if (hdrIdx == 4'd9) begin
                            if (plenQ == '0) begin
                                byte_valid <= 1'b0;
                                byte_last  <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                state      <= Done;
                            end else begin
                                state <= Param;
                            end
                        end else begin
                            hdrIdx    <= hdrIdx + 4'd1;
                            byte_out  <= hdrByte(hdrIdx + 4'd1, tagQ, rsp_size, codeQ);
                            byte_last <= (hdrIdx == 4'd8) && (plenQ == '0);
                        end
                    end
                end
                Param: begin
                    if (paramEnd) begin
                        byte_valid <= 1'b0;
                        byte_last  <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= Done;
                    end else if (adv && !loadParam) begin
                        byte_valid <= 1'b0;
                    end
                end
                Done: begin
                    done  <= 1'b0;
                    state <= Idle;
                end
                default: state <= Idle;
            endcase

            if (loadParam) begin
                byte_out   <= nextParamByte;
                byte_valid <= 1'b1;
                byte_last  <= (outCnt == plenQ - PlenW'(1));
                outCnt     <= outCnt + PlenW'(1);
            end

            if ((state == Hdr) || (state == Param)) begin
                rdPend    <= param_rd_en;
                skidValid <= skidNextValid;
                skidData  <= skidNextData;
                // The address parks on the last byte so it never points past the area.
                if (param_rd_en) begin
                    if (PlenW'(rdAddr) == plenQ - PlenW'(1)) begin
                        rdDone <= 1'b1;
                    end else begin
                        rdAddr <= rdAddr + PARAM_AW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tpm_response_marshaller.sv
// Directed, table-driven bench for tpm_response_marshaller with a sync-read parameter RAM.
module tb_tpm_response_marshaller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rsp_start;
    logic [15:0] rsp_tag;
    logic [31:0] rsp_code;
    logic [15:0] param_len;
    logic        param_rd_en;
    logic [5:0]  param_rd_addr;
    logic [7:0]  param_rd_data;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        busy;
    logic        done;
    logic [31:0] rsp_size;

    always #5 clock = ~clock;

    tpm_response_marshaller #(.MAX_PARAM_BYTES(64), .PARAM_AW(6)) dut (
        .clock(clock), .reset_n(reset_n), .rsp_start(rsp_start), .rsp_tag(rsp_tag),
        .rsp_code(rsp_code), .param_len(param_len), .param_rd_en(param_rd_en),
        .param_rd_addr(param_rd_addr), .param_rd_data(param_rd_data), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last), .busy(busy),
        .done(done), .rsp_size(rsp_size)
    );

    logic [7:0] mem [64];
    always @(posedge clock) if (param_rd_en) param_rd_data <= mem[param_rd_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] tag;
        logic [31:0] code;
        logic [15:0] plen;
        int          readyMode;   // 0: always ready, 1: random stalls
        int          midStart;    // accepted-byte count at which a stray start is pulsed, -1 none
        bit          startInDone;
        logic [15:0] expTag;
        logic [31:0] expCode;
        logic [31:0] expSize;
    } vec_t;

    task automatic checkAllZero(input string name);
        check(name, {byte_valid, byte_last, busy, done, param_rd_en, byte_out, rsp_size},
              '0);
    endtask

    task automatic runRsp(input vec_t v, input string nm, input int abortAt);
        logic [7:0] expB[$];
        logic [7:0] got[$];
        logic       gotLast[$];
        int         reads[64];
        int         expPlen, doneCyc, lastAcc, badReads, lastCount, byteErr;
        bit         prevStall, bnd9, bnd10, midDone;
        logic [9:0] prevOut;
        logic [31:0] sz;
        doneCyc = -1; lastAcc = -1; prevStall = 0; bnd9 = 0; bnd10 = 0; midDone = 0;
        prevOut = '0;
        sz = v.expSize;
        expPlen = int'(v.expSize) - 10;
        expB = '{v.expTag[15:8], v.expTag[7:0], sz[31:24], sz[23:16], sz[15:8], sz[7:0],
                 v.expCode[31:24], v.expCode[23:16], v.expCode[15:8], v.expCode[7:0]};
        for (int k = 0; k < expPlen; k++) expB.push_back(mem[k]);
        for (int k = 0; k < 64; k++) reads[k] = 0;

        @(negedge clock);
        rsp_tag = v.tag; rsp_code = v.code; param_len = v.plen; rsp_start = 1'b1;
        byte_ready = 1'b1;
        #1;
        check({nm, " idle before start"}, {busy, done, byte_valid}, 3'b000);

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            rsp_start = 1'b0;
            if (abortAt >= 0 && got.size() == abortAt) return;
            if (v.midStart >= 0 && got.size() == v.midStart && !midDone) begin
                rsp_start = 1'b1; rsp_code = 32'h0000_0100; param_len = 16'd0;
                rsp_tag = 16'h1234; midDone = 1;
            end
            if (v.readyMode == 0) begin
                byte_ready = 1'b1;
            end else begin
                byte_ready = ($urandom_range(0, 1) == 1);
                if (got.size() == 9 && !bnd9) begin byte_ready = 1'b0; bnd9 = 1; end
                else if (got.size() == 10 && !bnd10) begin byte_ready = 1'b0; bnd10 = 1; end
            end
            #1;
            if (cyc == 0) check({nm, " first cycle busy/valid"}, {busy, byte_valid}, 2'b11);
            if (prevStall) check({nm, " stall hold"}, {byte_valid, byte_last, byte_out},
                                 prevOut);
            if (param_rd_en) reads[param_rd_addr]++;
            if (byte_valid && byte_ready) begin
                got.push_back(byte_out);
                gotLast.push_back(byte_last);
                lastAcc = cyc;
            end
            if (done) begin
                doneCyc = cyc;
                break;
            end
            prevStall = byte_valid && !byte_ready;
            prevOut = {1'b1, byte_last, byte_out};
        end

        check({nm, " done seen"}, 32'(doneCyc >= 0), 32'd1);
        check({nm, " busy low at done"}, {31'd0, busy}, 32'd0);
        check({nm, " byte count"}, got.size(), v.expSize);
        byteErr = 0;
        for (int i = 0; i < got.size() && i < expB.size(); i++) begin
            if (got[i] !== expB[i]) begin
                byteErr++;
                $display("FAIL %s byte %0d: got %h, expected %h", nm, i, got[i], expB[i]);
            end
        end
        check({nm, " byte values wrong"}, byteErr, 0);
        lastCount = 0;
        foreach (gotLast[i]) if (gotLast[i]) lastCount++;
        check({nm, " byte_last count"}, lastCount, 1);
        if (gotLast.size() > 0)
            check({nm, " byte_last on final"}, {31'd0, gotLast[gotLast.size()-1]}, 32'd1);
        badReads = 0;
        for (int k = 0; k < 64; k++) if (reads[k] != ((k < expPlen) ? 1 : 0)) badReads++;
        check({nm, " buffer reads"}, badReads, 0);
        check({nm, " rsp_size"}, rsp_size, v.expSize);
        if (v.readyMode == 0) check({nm, " done latency"}, doneCyc, v.expSize);
        else check({nm, " done after last accept"}, doneCyc, lastAcc + 1);

        if (v.startInDone) begin
            rsp_start = 1'b1; rsp_code = 32'h0; param_len = 16'd1;
            @(negedge clock);
            rsp_start = 1'b0;
            #1;
            check({nm, " start in done ignored"}, {busy, byte_valid, done}, 3'b000);
        end
    endtask

    vec_t vecs[8];
    vec_t t2;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 17);
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC;
        reset_n = 1'b0; rsp_start = 1'b0; rsp_tag = '0; rsp_code = '0; param_len = '0;
        byte_ready = 1'b1;

        t2 = '{16'h8002, 32'h0, 16'd3, 0, -1, 0, 16'h8002, 32'h0, 32'd13};
        vecs[0] = '{16'h8002, 32'h0000_0100, 16'd5, 0, -1, 0, 16'h8001, 32'h0000_0100, 32'd10};
        vecs[1] = t2;
        vecs[2] = '{16'h8002, 32'h0, 16'd3, 1, -1, 0, 16'h8002, 32'h0, 32'd13};
        vecs[3] = '{16'h8002, 32'h0, 16'd65, 0, -1, 1, 16'h8001, 32'h0000_0101, 32'd10};
        vecs[4] = '{16'h8002, 32'h0, 16'd3, 0, 4, 0, 16'h8002, 32'h0, 32'd13};
        vecs[5] = '{16'h8002, 32'h0000_0100, 16'd0, 0, -1, 0, 16'h8001, 32'h0000_0100, 32'd10};
        vecs[6] = '{16'h8002, 32'h0, 16'd64, 1, -1, 0, 16'h8002, 32'h0, 32'd74};
        vecs[7] = '{16'h8002, 32'h0, 16'd1, 0, -1, 0, 16'h8002, 32'h0, 32'd11};

        repeat (2) @(negedge clock);
        #1;
        checkAllZero("reset state");
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) runRsp(vecs[i], $sformatf("vec%0d", i), -1);

        // Reset while byte 11 of a parameter response is presented.
        runRsp(t2, "pre-reset", 11);
        #1;
        reset_n = 1'b0;
        #1;
        checkAllZero("async reset mid-param");
        repeat (2) @(negedge clock);
        #1;
        checkAllZero("held in reset");
        reset_n = 1'b1;
        runRsp(t2, "after reset", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
